// File: rtl/mem_beh_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_beh_pkg
//  Description : Shared constants, types and helpers for the mem_beh_nru
//                behavioural multi-port memory model.
//                MAX_LATENCY - upper bound (exclusive) on read latency
//                ERR_CNT_W   - width of the protocol-error counter
//                rdmode_e    - cross-port same-address read behaviour
//                err_sat_add - saturating add for the error counter
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_beh_pkg;

    localparam int MAX_LATENCY = 30;
    localparam int ERR_CNT_W   = 16;

    typedef enum logic {
        RD_OLD = 1'b0,
        RD_NEW = 1'b1
    } rdmode_e;

    // Adds a per-cycle violation count to the error counter, clamping at
    // all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] err_sat_add(
        input logic [ERR_CNT_W-1:0] cnt,
        input logic [7:0]           inc
    );
        logic [ERR_CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(ERR_CNT_W-7){1'b0}}, inc};
        if (sum[ERR_CNT_W]) begin
            return '1;
        end
        return sum[ERR_CNT_W-1:0];
    endfunction

endpackage : mem_beh_pkg
`default_nettype wire

// File: rtl/mem_beh_rd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mem_beh_rd_pipe
//  Description : Per-port read return pipeline. Carries read data, valid and
//                the two error flags through LATENCY register stages.
//                LATENCY = 0 gives a combinational pass-through.
//  Ports       : clk, rst (sync, active-low)
//                in_vld/in_data/in_serr/in_derr - read launched this cycle
//                dout/dout_vld/read_serr/read_derr - returned read
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_beh_rd_pipe #(
    parameter int DW      = 32,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [DW-1:0] in_data,
    input  logic          in_serr,
    input  logic          in_derr,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          read_serr,
    output logic          read_derr
);

    generate
        if (LATENCY == 0) begin : g_comb
            logic w_unused_clk;
            assign w_unused_clk = clk ^ rst;

            assign dout      = in_data;
            assign dout_vld  = in_vld;
            assign read_serr = in_serr;
            assign read_derr = in_derr;
        end else begin : g_pipe
            logic [DW-1:0]      r_data [LATENCY];
            logic [LATENCY-1:0] r_vld;
            logic [LATENCY-1:0] r_serr;
            logic [LATENCY-1:0] r_derr;

            // Data and flags are zeroed on entry when no read is launched so
            // that the output is 0 whenever dout_vld is low.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_vld  <= '0;
                    r_serr <= '0;
                    r_derr <= '0;
                    for (int i = 0; i < LATENCY; i++) begin
                        r_data[i] <= '0;
                    end
                end else begin
                    r_vld[0]  <= in_vld;
                    r_data[0] <= in_vld ? in_data : '0;
                    r_serr[0] <= in_vld & in_serr;
                    r_derr[0] <= in_vld & in_derr;
                    for (int i = 1; i < LATENCY; i++) begin
                        r_vld[i]  <= r_vld[i-1];
                        r_data[i] <= r_data[i-1];
                        r_serr[i] <= r_serr[i-1];
                        r_derr[i] <= r_derr[i-1];
                    end
                end
            end

            assign dout      = r_data[LATENCY-1];
            assign dout_vld  = r_vld[LATENCY-1];
            assign read_serr = r_serr[LATENCY-1];
            assign read_derr = r_derr[LATENCY-1];
        end
    endgenerate

endmodule : mem_beh_rd_pipe
`default_nettype wire

// File: rtl/mem_beh_nru.sv
`default_nettype none
// ============================================================================
//  Module      : mem_beh_nru
//  Description : N-port behavioural memory model. Every port may read and/or
//                write each cycle with per-bit write enables; reads return
//                after LATENCY cycles with a valid strobe. Counts protocol
//                violations in a saturating counter.
//  Ports       : clk, rst (sync, active-low)
//                read/write [NP], addr [NP*AW], din/bw [NP*DW]
//                dout [NP*DW], dout_vld/read_serr/read_derr [NP]
//                inj_serr/inj_derr [NP], err_cnt [16]
//  Options     : MEM_BEH_ERRINJ_EN - enables single/double-bit read error
//                injection; when undefined inj_* are ignored and the error
//                flags are tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_beh_nru
    import mem_beh_pkg::*;
#(
    parameter int NP      = 2,
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int WORDS   = 1024,
    parameter int LATENCY = 2,
    parameter int RDMODE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NP-1:0]        read,
    input  logic [NP-1:0]        write,
    input  logic [NP*AW-1:0]     addr,
    input  logic [NP*DW-1:0]     din,
    input  logic [NP*DW-1:0]     bw,
    output logic [NP*DW-1:0]     dout,
    output logic [NP-1:0]        dout_vld,
    output logic [NP-1:0]        read_serr,
    output logic [NP-1:0]        read_derr,
    input  logic [NP-1:0]        inj_serr,
    input  logic [NP-1:0]        inj_derr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int      c_IW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam rdmode_e c_RDMODE = (RDMODE != 0) ? RD_NEW : RD_OLD;

    generate
        if (LATENCY >= MAX_LATENCY || NP < 1 || WORDS > 2**AW) begin : g_bad_cfg
            $fatal(1, "mem_beh_nru: illegal parameters LATENCY=%0d NP=%0d WORDS=%0d AW=%0d",
                   LATENCY, NP, WORDS, AW);
        end
    endgenerate

    logic [DW-1:0]        r_mem [WORDS];
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic [AW-1:0]   w_addr   [NP];
    logic [c_IW-1:0] w_idx    [NP];
    logic [DW-1:0]   w_din    [NP];
    logic [DW-1:0]   w_bw     [NP];
    logic [DW-1:0]   w_post   [NP];
    logic [DW-1:0]   w_rd_raw [NP];
    logic [DW-1:0]   w_rd_data[NP];
    logic [NP-1:0]   w_inr;
    logic [NP-1:0]   w_we;
    logic [NP-1:0]   w_rd_vld;
    logic [NP-1:0]   w_rd_serr;
    logic [NP-1:0]   w_rd_derr;
    logic [7:0]      w_err_inc;
    logic            w_first;
    logic            w_ovl;

    // Port decode; nothing is accepted while reset is asserted.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            w_addr[p]   = addr[p*AW +: AW];
            w_din[p]    = din[p*DW +: DW];
            w_bw[p]     = bw[p*DW +: DW];
            w_idx[p]    = w_addr[p][c_IW-1:0];
            w_inr[p]    = (32'(w_addr[p]) < 32'(WORDS));
            w_we[p]     = rst & write[p] & w_inr[p];
            w_rd_vld[p] = rst & read[p];
        end
    end

    // Post-write value of the word at each port's address: every enabled write
    // to that address is merged in ascending port order, so the highest port
    // owns overlapping bits. All ports writing one address then store the
    // same merged word, and RD_NEW reads see it too.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            w_post[p] = w_inr[p] ? r_mem[w_idx[p]] : '0;
            for (int q = 0; q < NP; q++) begin
                if (w_we[q] && (w_addr[q] == w_addr[p])) begin
                    w_post[p] = (~w_bw[q] & w_post[p]) | (w_bw[q] & w_din[q]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (w_we[p]) begin
                r_mem[w_idx[p]] <= w_post[p];
            end
        end
    end

    // Read data selection; out-of-range reads return unknown data.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            if (!w_inr[p]) begin
                w_rd_raw[p] = {DW{1'bx}};
            end else if (c_RDMODE == RD_NEW) begin
                w_rd_raw[p] = w_post[p];
            end else begin
                w_rd_raw[p] = r_mem[w_idx[p]];
            end
        end
    end

`ifdef MEM_BEH_ERRINJ_EN
    // Double-bit injection wins over single-bit when both are requested.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            w_rd_derr[p] = w_rd_vld[p] & inj_derr[p];
            w_rd_serr[p] = w_rd_vld[p] & inj_serr[p] & ~inj_derr[p];
            w_rd_data[p] = w_rd_raw[p] ^
                           {{(DW-2){1'b0}}, w_rd_derr[p], w_rd_derr[p] | w_rd_serr[p]};
        end
    end
`else
    logic w_unused_inj;
    assign w_unused_inj = ^{inj_serr, inj_derr};

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            w_rd_derr[p] = 1'b0;
            w_rd_serr[p] = 1'b0;
            w_rd_data[p] = w_rd_raw[p];
        end
    end
`endif

    // Protocol violations this cycle. Overlapping writes are attributed to
    // the lowest-index in-range writer of an address so each address counts
    // at most once.
    always_comb begin
        w_err_inc = '0;
        w_first   = 1'b0;
        w_ovl     = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (rst) begin
                if (read[p] && write[p]) begin
                    w_err_inc = w_err_inc + 8'd1;
                end
                if ((read[p] || write[p]) && !w_inr[p]) begin
                    w_err_inc = w_err_inc + 8'd1;
                end
            end
            if (w_we[p]) begin
                w_first = 1'b1;
                w_ovl   = 1'b0;
                for (int q = 0; q < p; q++) begin
                    if (w_we[q] && (w_addr[q] == w_addr[p])) begin
                        w_first = 1'b0;
                    end
                end
                for (int q = 0; q < NP; q++) begin
                    for (int r = q + 1; r < NP; r++) begin
                        if (w_we[q] && w_we[r] &&
                            (w_addr[q] == w_addr[p]) && (w_addr[r] == w_addr[p]) &&
                            (|(w_bw[q] & w_bw[r]))) begin
                            w_ovl = 1'b1;
                        end
                    end
                end
                if (w_first && w_ovl) begin
                    w_err_inc = w_err_inc + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err_cnt <= '0;
        end else begin
            r_err_cnt <= err_sat_add(r_err_cnt, w_err_inc);
        end
    end

    assign err_cnt = r_err_cnt;

    generate
        for (genvar p = 0; p < NP; p++) begin : g_port
            mem_beh_rd_pipe #(
                .DW      (DW),
                .LATENCY (LATENCY)
            ) u_rd_pipe (
                .clk       (clk),
                .rst       (rst),
                .in_vld    (w_rd_vld[p]),
                .in_data   (w_rd_data[p]),
                .in_serr   (w_rd_serr[p]),
                .in_derr   (w_rd_derr[p]),
                .dout      (dout[p*DW +: DW]),
                .dout_vld  (dout_vld[p]),
                .read_serr (read_serr[p]),
                .read_derr (read_derr[p])
            );
        end
    endgenerate

endmodule : mem_beh_nru
`default_nettype wire

// File: tb/tb_mem_beh_nru.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_beh_nru
//  Description : Self-checking bench for mem_beh_nru. Two instances share all
//                inputs, one reading old data on collisions and one reading
//                write-through data. A queue-based reference model predicts
//                read returns and the protocol-error count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_beh_nru;

    localparam int NP      = 2;
    localparam int AW      = 10;
    localparam int DW      = 32;
    localparam int WORDS   = 1000;
    localparam int LATENCY = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     read, write, inj_serr, inj_derr;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  din, bw;
    logic [NP*DW-1:0]  dout_o, dout_n;
    logic [NP-1:0]     vld_o, vld_n, serr_o, serr_n, derr_o, derr_n;
    logic [15:0]       err_o, err_n;

    always #5 clk = ~clk;

    mem_beh_nru #(.NP(NP), .AW(AW), .DW(DW), .WORDS(WORDS), .LATENCY(LATENCY), .RDMODE(0)) u_dut_old (
        .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr), .din(din), .bw(bw),
        .dout(dout_o), .dout_vld(vld_o), .read_serr(serr_o), .read_derr(derr_o),
        .inj_serr(inj_serr), .inj_derr(inj_derr), .err_cnt(err_o)
    );

    mem_beh_nru #(.NP(NP), .AW(AW), .DW(DW), .WORDS(WORDS), .LATENCY(LATENCY), .RDMODE(1)) u_dut_new (
        .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr), .din(din), .bw(bw),
        .dout(dout_n), .dout_vld(vld_n), .read_serr(serr_n), .read_derr(derr_n),
        .inj_serr(inj_serr), .inj_derr(inj_derr), .err_cnt(err_n)
    );

    typedef struct {
        int          due;
        int          port;
        logic [31:0] d_old;
        logic [31:0] d_new;
        bit          serr;
        bit          derr;
        bit          oor;
    } rd_t;

    logic [31:0] m [WORDS];
    rd_t         sq[$];
    int          exp_err = 0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    string       tg[2] = '{"p0_", "p1_"};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic idle_in();
        read = '0; write = '0; addr = '0; din = '0; bw = '0;
        inj_serr = '0; inj_derr = '0;
    endtask

    task automatic set_port(input int p, input bit rd, input bit wr, input logic [9:0] a,
                            input logic [31:0] d, input logic [31:0] mask);
        read[p] = rd;
        write[p] = wr;
        addr[p*AW +: AW] = a;
        din[p*DW +: DW] = d;
        bw[p*DW +: DW] = mask;
    endtask

    task automatic check_outputs();
        bit          ev[2], es[2], ed[2], eo[2];
        logic [31:0] eold[2], enew[2];
        rd_t         e;
        for (int p = 0; p < 2; p++) begin
            ev[p] = 0; es[p] = 0; ed[p] = 0; eo[p] = 0; eold[p] = '0; enew[p] = '0;
        end
        while (sq.size() > 0 && sq[0].due <= cyc) begin
            e = sq.pop_front();
            if (e.due == cyc) begin
                ev[e.port] = 1; es[e.port] = e.serr; ed[e.port] = e.derr; eo[e.port] = e.oor;
                eold[e.port] = e.d_old; enew[e.port] = e.d_new;
            end
        end
        for (int p = 0; p < 2; p++) begin
            check({tg[p], "vld_old"}, 32'(vld_o[p]), 32'(ev[p]));
            check({tg[p], "vld_new"}, 32'(vld_n[p]), 32'(ev[p]));
            if (!eo[p]) begin
                check({tg[p], "dout_old"}, dout_o[p*DW +: DW], eold[p]);
                check({tg[p], "dout_new"}, dout_n[p*DW +: DW], enew[p]);
            end
            check({tg[p], "serr_old"}, 32'(serr_o[p]), 32'(es[p]));
            check({tg[p], "serr_new"}, 32'(serr_n[p]), 32'(es[p]));
            check({tg[p], "derr_old"}, 32'(derr_o[p]), 32'(ed[p]));
            check({tg[p], "derr_new"}, 32'(derr_n[p]), 32'(ed[p]));
        end
        check("err_cnt_old", 32'(err_o), 32'(exp_err));
        check("err_cnt_new", 32'(err_n), 32'(exp_err));
    endtask

    // Applies the current inputs to the model, advances one clock and checks.
    task automatic step();
        int          viol;
        logic [31:0] seen [int];
        bit          flg [int];
        logic [31:0] old_d [2];
        logic [9:0]  a;
        logic [31:0] msk;
        rd_t         e;
        if (rst) begin
            viol = 0;
            for (int p = 0; p < 2; p++) begin
                a = addr[p*AW +: AW];
                old_d[p] = (32'(a) < WORDS) ? m[a] : 32'h0;
                if (read[p] && write[p]) viol++;
                if ((read[p] || write[p]) && 32'(a) >= WORDS) viol++;
            end
            for (int p = 0; p < 2; p++) begin
                a = addr[p*AW +: AW];
                msk = bw[p*DW +: DW];
                if (write[p] && 32'(a) < WORDS) begin
                    if (seen.exists(int'(a))) begin
                        if ((seen[int'(a)] & msk) != 0) flg[int'(a)] = 1;
                        seen[int'(a)] = seen[int'(a)] | msk;
                    end else begin
                        seen[int'(a)] = msk;
                    end
                    m[a] = (m[a] & ~msk) | (din[p*DW +: DW] & msk);
                end
            end
            viol += flg.num();
            for (int p = 0; p < 2; p++) begin
                if (read[p]) begin
                    a = addr[p*AW +: AW];
                    e.due = cyc + LATENCY;
                    e.port = p;
                    e.oor = (32'(a) >= WORDS);
                    e.d_old = old_d[p];
                    e.d_new = e.oor ? 32'h0 : m[a];
                    e.serr = 0;
                    e.derr = 0;
`ifdef MEM_BEH_ERRINJ_EN
                    if (inj_derr[p]) begin
                        e.derr = 1; e.d_old ^= 32'h3; e.d_new ^= 32'h3;
                    end else if (inj_serr[p]) begin
                        e.serr = 1; e.d_old ^= 32'h1; e.d_new ^= 32'h1;
                    end
`endif
                    sq.push_back(e);
                end
            end
            exp_err = (exp_err + viol > 65535) ? 65535 : exp_err + viol;
        end else begin
            exp_err = 0;
            while (sq.size() > 0 && sq[$].due > cyc) void'(sq.pop_back());
        end
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle_steps(input int n);
        idle_in();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [31:0] exp_inj;
        idle_in();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;

        // Fill the memory with zeros, two words per cycle.
        for (int i = 0; i < WORDS; i += 2) begin
            idle_in();
            set_port(0, 0, 1, 10'(i), 32'h0, 32'hFFFF_FFFF);
            set_port(1, 0, 1, 10'(i + 1), 32'h0, 32'hFFFF_FFFF);
            step();
        end

        // Write then read on the other port, two-cycle return.
        idle_in();
        set_port(0, 0, 1, 10'd5, 32'hA5A5_0000, 32'hFFFF_FFFF);
        step();
        idle_in();
        set_port(1, 1, 0, 10'd5, 32'h0, 32'h0);
        step();
        idle_steps(1);
        check("d1_dout", dout_o[63:32], 32'hA5A5_0000);
        check("d1_vld", 32'(vld_o[1]), 32'h1);
        check("d1_err", 32'(err_o), 32'h0);

        // Overlapping writes to one address: port1 wins bits 23:16.
        idle_in();
        set_port(0, 0, 1, 10'd7, 32'h1111_1111, 32'hFFFF_0000);
        set_port(1, 0, 1, 10'd7, 32'h2222_2222, 32'h00FF_FF00);
        step();
        check("d2_err", 32'(err_o), 32'h1);
        idle_in();
        set_port(0, 1, 0, 10'd7, 32'h0, 32'h0);
        step();
        idle_steps(1);
        check("d2_dout", dout_o[31:0], 32'h1122_2200);

        // Same-address cross-port read/write.
        idle_in();
        set_port(0, 0, 1, 10'd3, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        set_port(1, 1, 0, 10'd3, 32'h0, 32'h0);
        step();
        idle_steps(1);
        check("d3_rd_old", dout_o[63:32], 32'h0);
        check("d3_rd_new", dout_n[63:32], 32'hDEAD_BEEF);

        // Error injection on a read of 0xA5A5_0000.
`ifdef MEM_BEH_ERRINJ_EN
        exp_inj = 32'hA5A5_0001;
`else
        exp_inj = 32'hA5A5_0000;
`endif
        idle_in();
        set_port(0, 1, 0, 10'd5, 32'h0, 32'h0);
        inj_serr[0] = 1'b1;
        step();
        idle_steps(1);
        check("inj_s_dout", dout_o[31:0], exp_inj);
`ifdef MEM_BEH_ERRINJ_EN
        exp_inj = 32'hA5A5_0003;
`endif
        idle_in();
        set_port(0, 1, 0, 10'd5, 32'h0, 32'h0);
        inj_derr[0] = 1'b1;
        step();
        idle_steps(1);
        check("inj_d_dout", dout_o[31:0], exp_inj);

        // Streaming reads interrupted by a one-cycle reset.
        for (int i = 0; i < 10; i++) begin
            idle_in();
            set_port(0, 1, 0, 10'(i), 32'h0, 32'h0);
            set_port(1, 1, 0, 10'(9 - i), 32'h0, 32'h0);
            rst = (i != 5);
            step();
        end
        rst = 1'b1;
        idle_steps(3);
        check("rst_err", 32'(err_o), 32'h0);
        for (int i = 0; i < 10; i++) begin
            idle_in();
            set_port(0, 1, 0, 10'(i), 32'h0, 32'h0);
            step();
        end
        idle_steps(3);

        // Randomised traffic with collisions, out-of-range accesses and resets.
        for (int i = 0; i < 1500; i++) begin
            idle_in();
            for (int p = 0; p < 2; p++) begin
                logic [9:0]  ra;
                logic [31:0] rm;
                ra = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(995, 1023))
                                                 : 10'($urandom_range(0, 15));
                case ($urandom_range(0, 2))
                    0:       rm = 32'hFFFF_FFFF;
                    1:       rm = 32'hFF << (8 * $urandom_range(0, 3));
                    default: rm = $urandom;
                endcase
                set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom, rm);
                inj_serr[p] = ($urandom_range(0, 3) == 0);
                inj_derr[p] = ($urandom_range(0, 3) == 0);
            end
            rst = ($urandom_range(0, 49) != 0);
            step();
        end
        rst = 1'b1;
        idle_steps(3);

        // Error counter saturation: two violations per cycle.
        rst = 1'b0;
        idle_steps(1);
        rst = 1'b1;
        idle_in();
        set_port(0, 1, 1, 10'(WORDS), 32'h0, 32'hFFFF_FFFF);
        step();
        check("sat_first", 32'(err_o), 32'h2);
        for (int i = 1; i < 70000; i++) step();
        check("sat_final", 32'(err_o), 32'h0000_FFFF);
        idle_steps(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_beh_nru
`default_nettype wire
